// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM fields become a req/ack data-memory access, and the result is registered for WB.
// Optional build macro ALIGN_CHECK_EN: misaligned half/word accesses complete with no bus access and pulse align_err.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_wbreg,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic        in_memwrite,
  input  logic        in_unsigned,
  input  logic        in_byte,
  input  logic        in_half,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_ir,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_regwrite,
`ifdef ALIGN_CHECK_EN
  output logic        align_err,
`endif
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        regwrite;
    logic        uns;
    logic        sz_byte;
    logic        sz_half;
  } access_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwrite;
  } wb_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  access_t       acc_q, acc_d;
  wb_t           wb_q, wb_d;
  logic          bus_err_q, bus_err_d;
  logic          align_err_q, align_err_d;
  logic          stall_c;

  logic        busy, mem_op, misaligned, timeout;
  logic [1:0]  a;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign busy    = (state_q == BUSY);
  assign mem_op  = in_valid & (in_memtoreg | in_memwrite);
  assign a       = in_addr[1:0];
  assign timeout = busy & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

`ifdef ALIGN_CHECK_EN
  assign misaligned = ~in_byte & (in_half ? a[0] : (a != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Byte wins over half when both are set; neither means word.
  always_comb begin
    if (in_byte) begin
      be_c    = 4'b0001 << a;
      wdata_c = {4{in_wdata[7:0]}};
    end else if (in_half) begin
      be_c    = a[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{in_wdata[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = in_wdata;
    end
  end

  assign rd_shift = dmem_rdata >> {acc_q.addr[1:0], 3'b000};
  assign rd_half  = acc_q.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    if (acc_q.sz_byte)
      load_data = {{24{~acc_q.uns & rd_shift[7]}}, rd_shift[7:0]};
    else if (acc_q.sz_half)
      load_data = {{16{~acc_q.uns & rd_half[15]}}, rd_half};
    else
      load_data = dmem_rdata;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    wb_d        = '0;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;
    stall_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && misaligned) begin
          wb_d.valid  = 1'b1;
          wb_d.ir     = in_ir;
          wb_d.pc     = in_pc;
          wb_d.rd     = in_wbreg;
          align_err_d = 1'b1;
        end else if (mem_op) begin
          stall_c = 1'b1;
          state_d = BUSY;
          cnt_d   = '0;
          acc_d   = '{addr: in_addr, be: be_c, wdata: wdata_c, ir: in_ir, pc: in_pc,
                      rd: in_wbreg, we: in_memwrite, regwrite: in_regwrite,
                      uns: in_unsigned, sz_byte: in_byte, sz_half: in_half};
        end else if (in_valid) begin
          wb_d = '{valid: 1'b1, ir: in_ir, pc: in_pc, data: in_addr,
                   rd: in_wbreg, regwrite: in_regwrite};
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d       = IDLE;
          wb_d.valid    = 1'b1;
          wb_d.ir       = acc_q.ir;
          wb_d.pc       = acc_q.pc;
          wb_d.rd       = acc_q.rd;
          wb_d.regwrite = acc_q.regwrite & ~acc_q.we;
          wb_d.data     = acc_q.we ? acc_q.addr : load_data;
        end else if (timeout) begin
          state_d    = IDLE;
          wb_d.valid = 1'b1;
          wb_d.ir    = acc_q.ir;
          wb_d.pc    = acc_q.pc;
          wb_d.rd    = acc_q.rd;
          bus_err_d  = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      wb_q        <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      wb_q        <= wb_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  // Stall is combinational from the inputs, so it is forced low while reset is held.
  assign stall      = stall_c & ~rst;
  assign dmem_req   = busy;
  assign dmem_we    = busy & acc_q.we;
  assign dmem_addr  = busy ? {acc_q.addr[31:2], 2'b00} : '0;
  assign dmem_be    = busy ? acc_q.be : '0;
  assign dmem_wdata = busy ? acc_q.wdata : '0;

  assign wb_valid    = wb_q.valid;
  assign wb_ir       = wb_q.ir;
  assign wb_pc       = wb_q.pc;
  assign wb_data     = wb_q.data;
  assign wb_reg      = wb_q.rd;
  assign wb_regwrite = wb_q.regwrite;
  assign bus_err     = bus_err_q;
`ifdef ALIGN_CHECK_EN
  assign align_err   = align_err_q;
`else
  logic unused_align;
  assign unused_align = align_err_q;
`endif

endmodule
